// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one imem read at a time and
// hands each returned word to decode with its PC.
// States: IDLE boot | REQ request out | WAIT awaiting data | HOLD word to decode | HALTED stopped
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fetch_fault
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] HALTED = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        fault_q, fault_d;
    logic        kill_q, kill_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        kill_d  = kill_q;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else if (imem_rsp_err) begin
                        fault_d = 1'b1;
                        state_d = HALTED;
                    end else begin
                        inst_d  = imem_rsp_data;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = REQ;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase

        // A redirect never latches data; kill marks a response whose request it overtook.
        if (redirect_valid && (state_q != HALTED)) begin
            pc_d    = redirect_pc;
            inst_d  = inst_q;
            fault_d = fault_q;
            if (redirect_pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
                state_d = HALTED;
            end else begin
                case (state_q)
                    REQ: begin
                        if (imem_req_ready) kill_d = 1'b1;
                    end
                    WAIT: begin
                        if (imem_rsp_valid) begin
                            kill_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            kill_d  = 1'b1;
                        end
                    end
                    default: state_d = REQ;
                endcase
            end
        end

        if (halt) begin
            state_d = HALTED;
            pc_d    = pc_q;
            inst_d  = inst_q;
            fault_d = fault_q;
            kill_d  = kill_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            fault_q <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            kill_q  <= kill_d;
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == HOLD);
    assign inst           = inst_q;
    assign pc             = pc_q;
    assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: memory and decode models drive the DUT, an architectural
// next-PC model queues expected (pc, word) pairs and a monitor checks each presentation.
module tb_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        imem_rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        fetch_fault;

    always #5 clk = ~clk;

    ifu #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .fetch_fault(fetch_fault)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] acc_q[$];
    int          rise_q[$];
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] cur_pc = 32'h0;
    logic [31:0] cur_inst = 32'h0;
    logic        prev_v = 1'b0;
    int          edge_cnt = 0;

    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_dly = 0;
    int          rdy_mode = 0;   // 0 always ready, 1 random, 2 never
    int          dec_mode = 1;   // 0 stall, 1 always ready, 2 random
    bit          lat_rand = 1'b0;
    int          lat_val = 0;
    bit          fixed13 = 1'b1;
    bit          err_inject = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (fixed13) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_pc_q.push_back(a);
        exp_inst_q.push_back(mem_word(a));
    endtask

    task automatic clear_exp();
        exp_pc_q.delete();
        exp_inst_q.delete();
    endtask

    // Monitor: pops one expectation per new presentation, checks stability while held.
    always @(negedge clk) begin
        if (inst_valid) begin
            if (!prev_v) begin
                rise_q.push_back(edge_cnt);
                if (exp_pc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_inst: got pc %h inst %h want nothing", pc, inst);
                end else begin
                    cur_pc   = exp_pc_q.pop_front();
                    cur_inst = exp_inst_q.pop_front();
                    check("present_pc", pc, cur_pc);
                    check("present_inst", inst, cur_inst);
                end
            end else begin
                check("hold_pc", pc, cur_pc);
                check("hold_inst", inst, cur_inst);
            end
        end
        prev_v = inst_valid;
    end

    task automatic cyc_start();
        @(negedge clk);
        #1;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        if (pend) begin
            if (pend_dly == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                imem_rsp_err   = err_inject;
                pend           = 1'b0;
            end else begin
                pend_dly--;
            end
        end
        case (rdy_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = ($urandom_range(0, 1) == 1);
            default: imem_req_ready = 1'b0;
        endcase
        if (imem_req_valid) begin
            total++;
            if (pend) begin
                bad++;
                $display("FAIL one_outstanding: got request %h while busy want no request", imem_req_addr);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            pend      = 1'b1;
            pend_addr = imem_req_addr;
            pend_dly  = lat_rand ? int'($urandom_range(0, lat_val)) : lat_val;
            acc_q.push_back(imem_req_addr);
        end
        case (dec_mode)
            0:       inst_ready = 1'b0;
            1:       inst_ready = 1'b1;
            default: inst_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    // Architectural next-PC rule: redirect target, else pc+4 after a consumed word.
    task automatic cyc_commit();
        if (halt) begin
            clear_exp();
        end else if (redirect_valid) begin
            exp_pc = redirect_pc;
            clear_exp();
            acc_q.delete();
            if (redirect_pc[1:0] == 2'b00) push_exp(exp_pc);
        end else if (inst_valid && inst_ready) begin
            exp_pc = exp_pc + 32'd4;
            push_exp(exp_pc);
        end
    endtask

    task automatic tick();
        cyc_start();
        cyc_commit();
    endtask

    task automatic wait_present(input int budget, input string name);
        int n0;
        n0 = rise_q.size();
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rise_q.size() > n0) return;
        end
        total++;
        bad++;
        $display("FAIL %s: got no inst_valid within %0d cycles want one", name, budget);
    endtask

    task automatic wait_accept(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (acc_q.size() > 0) return;
            tick();
        end
        if (acc_q.size() > 0) return;
        total++;
        bad++;
        $display("FAIL %s: got no accepted request within %0d cycles want one", name, budget);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        pend           = 1'b0;
        err_inject     = 1'b0;
        clear_exp();
        acc_q.delete();
        rise_q.delete();
        repeat (2) @(negedge clk);
        #1;
        rst    = 1'b1;
        exp_pc = RESET_PC;
        push_exp(exp_pc);
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] saved;
        bit          found;

        // Zero-wait fetch timing and sequential addresses
        rdy_mode = 0; dec_mode = 1; lat_rand = 1'b0; lat_val = 0; fixed13 = 1'b1;
        do_reset();
        for (int i = 0; i < 40 && rise_q.size() < 3; i++) tick();
        if (rise_q.size() < 3) timeout_fail("first_three_insts");
        else begin
            check("rise_cycle_1", 32'(rise_q[0]), 32'd3);
            check("rise_cycle_2", 32'(rise_q[1]), 32'd6);
            check("rise_cycle_3", 32'(rise_q[2]), 32'd9);
        end
        if (acc_q.size() < 3) timeout_fail("first_three_reqs");
        else begin
            check("fetch_addr_0", acc_q[0], 32'h8000_0000);
            check("fetch_addr_1", acc_q[1], 32'h8000_0004);
            check("fetch_addr_2", acc_q[2], 32'h8000_0008);
        end

        // Decode back-pressure in HOLD
        dec_mode = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc_start();
            if (inst_valid) begin found = 1'b1; break; end
            cyc_commit();
        end
        if (!found) timeout_fail("stall_reach_hold");
        saved = exp_pc;
        cyc_commit();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_inst_valid", {31'h0, inst_valid}, 32'd1);
            check("stall_no_req", {31'h0, imem_req_valid}, 32'd0);
            check("stall_pc", pc, saved);
        end
        dec_mode = 1;
        tick();
        wait_present(20, "after_stall");
        check("after_stall_pc", pc, saved + 32'd4);

        // Redirect in WAIT, stale response two cycles later
        lat_val = 2;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc_start();
            if (pend && !imem_req_valid && !inst_valid && !imem_rsp_valid) begin
                fixed13        = 1'b0;
                redirect_valid = 1'b1;
                redirect_pc    = 32'h8000_0100;
                cyc_commit();
                found = 1'b1;
                break;
            end
            cyc_commit();
        end
        if (!found) timeout_fail("reach_wait");
        wait_accept(20, "req_after_wait_redirect");
        if (acc_q.size() > 0) check("wait_redirect_addr", acc_q[0], 32'h8000_0100);
        wait_present(20, "inst_after_wait_redirect");
        check("wait_redirect_pc", pc, 32'h8000_0100);
        check("wait_redirect_inst", inst, mem_word(32'h8000_0100));

        // Redirect coinciding with an inst handshake
        lat_rand = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc_start();
            if (inst_valid && inst_ready) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h8000_0040;
                cyc_commit();
                found = 1'b1;
                break;
            end
            cyc_commit();
        end
        if (!found) timeout_fail("reach_handshake");
        wait_accept(20, "req_after_hs_redirect");
        if (acc_q.size() > 0) check("hs_redirect_addr", acc_q[0], 32'h8000_0040);
        wait_present(20, "inst_after_hs_redirect");
        check("hs_redirect_pc", pc, 32'h8000_0040);

        // Misaligned redirect
        tick();
        cyc_start();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        cyc_commit();
        tick();
        check("misalign_fault", {31'h0, fetch_fault}, 32'd1);
        check("misalign_pc", pc, 32'h8000_0102);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("misalign_quiet", {30'h0, imem_req_valid, inst_valid}, 32'd0);
        end

        // Bus error on the first response
        lat_rand = 1'b0; lat_val = 0;
        do_reset();
        err_inject = 1'b1;
        clear_exp();
        for (int i = 0; i < 20 && !fetch_fault; i++) tick();
        check("buserr_fault", {31'h0, fetch_fault}, 32'd1);
        check("buserr_pc", pc, RESET_PC);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("buserr_quiet", {30'h0, imem_req_valid, inst_valid}, 32'd0);
        end
        err_inject = 1'b0;

        // halt while a request is stalled
        rdy_mode = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc_start();
            if (imem_req_valid) begin
                halt = 1'b1;
                cyc_commit();
                found = 1'b1;
                break;
            end
            cyc_commit();
        end
        if (!found) timeout_fail("reach_req_for_halt");
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halt_no_req", {30'h0, imem_req_valid, inst_valid}, 32'd0);
        end
        check("halt_no_fault", {31'h0, fetch_fault}, 32'd0);

        // Randomized traffic with aligned redirects, including the 32-bit wrap
        rdy_mode = 1; dec_mode = 2; lat_rand = 1'b1; lat_val = 3; fixed13 = 1'b0;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            cyc_start();
            if ($urandom_range(0, 11) == 0) begin
                int r;
                r = int'($urandom_range(0, 7));
                redirect_valid = 1'b1;
                if (r == 0)      redirect_pc = 32'hFFFF_FFF8;
                else if (r == 1) redirect_pc = 32'hFFFF_FFFC;
                else             redirect_pc = RESET_PC + 32'($urandom_range(0, 255) * 4);
            end
            cyc_commit();
        end
        check("random_progress", {31'h0, rise_q.size() >= 50}, 32'd1);

        // Reset asserted mid-WAIT
        rdy_mode = 0; dec_mode = 1; lat_rand = 1'b0; lat_val = 4;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc_start();
            if (pend && !imem_req_valid && !inst_valid && !imem_rsp_valid) begin
                found = 1'b1;
                break;
            end
            cyc_commit();
        end
        if (!found) timeout_fail("reach_wait_for_reset");
        rst  = 1'b0;
        pend = 1'b0;
        clear_exp();
        #1;
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_inst_valid", {31'h0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", pc, RESET_PC);
        check("rst_fault", {31'h0, fetch_fault}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
